// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and widths for receiver and transmitter
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int COMP_W = 16;
    localparam int BIT_CW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RECEIVE = 2'd2,
        STOP    = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous input, configurable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver, mid-bit sampling, valid/ack output with error pulses
module uart_receiver
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [COMP_W-1:0] comp,
    input  logic              rec_en,
    input  logic              uart_rx,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_overrun
);

    logic rx_s;
    logic rx_p;

    uart_state_e       state, state_n;
    logic [COMP_W-1:0] comp_int, comp_int_n;
    logic [COMP_W-1:0] comp_c, comp_c_n;
    logic [BIT_CW-1:0] bit_c, bit_c_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              frame_err_n;
    logic              overrun_n;
    logic              deliver;
    logic [COMP_W-1:0] half;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uart_rx),
        .q      (rx_s)
    );

    // Edge-detect history keeps running while disabled so a line held low never fakes a start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_p <= 1'b1;
        end else begin
            rx_p <= rx_s;
        end
    end

    assign half = comp_int >> 1;

    always_comb begin
        state_n     = state;
        comp_int_n  = comp_int;
        comp_c_n    = comp_c;
        bit_c_n     = bit_c;
        shreg_n     = shreg;
        data_n      = rx_data;
        valid_n     = rx_valid;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        deliver     = 1'b0;

        case (state)
            IDLE: begin
                comp_c_n = '0;
                bit_c_n  = '0;
                if (rx_p && !rx_s) begin
                    state_n    = START;
                    comp_int_n = comp;
                end
            end
            START: begin
                comp_c_n = comp_c + 16'd1;
                if (comp_c == half) begin
                    comp_c_n = '0;
                    bit_c_n  = '0;
                    state_n  = rx_s ? IDLE : RECEIVE;
                end
            end
            RECEIVE: begin
                comp_c_n = comp_c + 16'd1;
                if (comp_c >= comp_int) begin
                    shreg_n  = {rx_s, shreg[DATA_W-1:1]};
                    comp_c_n = '0;
                    bit_c_n  = bit_c + 4'd1;
                    if (bit_c == 4'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                comp_c_n = comp_c + 16'd1;
                if (comp_c >= comp_int) begin
                    comp_c_n = '0;
                    state_n  = IDLE;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // An ack landing on the deliver cycle frees the holding register for the new byte.
        if (deliver) begin
            if (!rx_valid || rx_ack) begin
                data_n  = shreg;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end else if (rx_valid && rx_ack) begin
            valid_n = 1'b0;
        end

        if (!rec_en) begin
            state_n     = IDLE;
            comp_int_n  = '0;
            comp_c_n    = '0;
            bit_c_n     = '0;
            shreg_n     = '0;
            data_n      = '0;
            valid_n     = 1'b0;
            frame_err_n = 1'b0;
            overrun_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            comp_int     <= '0;
            comp_c       <= '0;
            bit_c        <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            state        <= state_n;
            comp_int     <= comp_int_n;
            comp_c       <= comp_c_n;
            bit_c        <= bit_c_n;
            shreg        <= shreg_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= frame_err_n;
            rx_overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] comp;
    logic        rec_en;
    logic        uart_rx;
    logic        ack_man;
    logic        ack_auto;
    logic        auto_ack;
    wire         rx_ack = ack_man | ack_auto;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        rx_overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_fe  = 0;
    int n_ov  = 0;
    int valid_cyc = 0;
    logic prev_v = 1'b0;
    logic [7:0] rx_log[$];

    uart_receiver dut (
        .clk          (clk),
        .resetn       (resetn),
        .comp         (comp),
        .rec_en       (rec_en),
        .uart_rx      (uart_rx),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_frame_err) n_fe <= n_fe + 1;
        if (rx_overrun) n_ov <= n_ov + 1;
        if (rx_valid && !prev_v) valid_cyc <= cyc;
        prev_v <= rx_valid;
        if (auto_ack && rx_valid && !ack_auto) begin
            rx_log.push_back(rx_data);
            ack_auto <= 1'b1;
        end else begin
            ack_auto <= 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One frame: start, 8 data bits LSB first, first stop bit = stp, then extra stop bits high.
    task automatic send_frame(input logic [7:0] d, input logic stp, input int nstop,
                              input int ack_at, output int t0);
        int per;
        int b;
        logic [7:0] dd;
        dd  = d;
        per = int'(comp) + 1;
        t0  = cyc;
        for (int i = 0; i < (9 + nstop) * per; i++) begin
            b = i / per;
            if (b == 0) uart_rx = 1'b0;
            else if (b <= 8) uart_rx = dd[b-1];
            else if (b == 9) uart_rx = stp;
            else uart_rx = 1'b1;
            ack_man = (i == ack_at);
            tick();
        end
        uart_rx = 1'b1;
        ack_man = 1'b0;
    endtask

    initial begin
        int t0;
        int fe0;
        int ov0;
        resetn   = 1'b0;
        comp     = 16'd15;
        rec_en   = 1'b1;
        uart_rx  = 1'b1;
        ack_man  = 1'b0;
        ack_auto = 1'b0;
        auto_ack = 1'b0;

        tick(3);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_fe", rx_frame_err, 1'b0);
        chk("rst_ov", rx_overrun, 1'b0);
        chk("rst_state", dut.state, uart_pkg::IDLE);
        resetn = 1'b1;
        tick(5);

        send_frame(8'hA5, 1'b1, 1, -1, t0);
        chk("a5_latency", valid_cyc - t0, 155);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_valid", rx_valid, 1'b1);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("a5_ack_clear", rx_valid, 1'b0);
        chk("a5_no_err", n_fe + n_ov, 0);

        auto_ack = 1'b1;
        send_frame(8'h3C, 1'b1, 2, -1, t0);
        send_frame(8'hFF, 1'b1, 2, -1, t0);
        tick(5);
        auto_ack = 1'b0;
        tick(2);
        chk("b2b_count", rx_log.size(), 2);
        chk("b2b_first", rx_log[0], 8'h3C);
        chk("b2b_second", rx_log[1], 8'hFF);
        chk("b2b_no_err", n_fe + n_ov, 0);

        fe0 = n_fe;
        ov0 = n_ov;
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(6);
        chk("glitch_in_start", dut.state, uart_pkg::START);
        tick();
        chk("glitch_idle", dut.state, uart_pkg::IDLE);
        tick(20);
        chk("glitch_valid", rx_valid, 1'b0);
        chk("glitch_pulses", (n_fe - fe0) + (n_ov - ov0), 0);

        send_frame(8'h55, 1'b0, 1, -1, t0);
        chk("fe_pulse_once", n_fe - fe0, 1);
        chk("fe_no_valid", rx_valid, 1'b0);
        tick(5);
        send_frame(8'h12, 1'b1, 1, -1, t0);
        chk("fe_next_data", rx_data, 8'h12);
        chk("fe_next_valid", rx_valid, 1'b1);
        chk("fe_no_more", n_fe - fe0, 1);

        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        chk("ov_pre_clear", rx_valid, 1'b0);
        ov0 = n_ov;
        send_frame(8'h11, 1'b1, 1, -1, t0);
        send_frame(8'h22, 1'b1, 1, -1, t0);
        tick(2);
        chk("ov_held", rx_data, 8'h11);
        chk("ov_valid", rx_valid, 1'b1);
        chk("ov_pulse_once", n_ov - ov0, 1);
        send_frame(8'h22, 1'b1, 1, 154, t0);
        tick(2);
        chk("ackdel_data", rx_data, 8'h22);
        chk("ackdel_valid", rx_valid, 1'b1);
        chk("ackdel_no_ov", n_ov - ov0, 1);

        uart_rx = 1'b0;
        tick(40);
        chk("dis_in_receive", dut.state, uart_pkg::RECEIVE);
        rec_en = 1'b0;
        tick();
        chk("dis_data", rx_data, 8'h00);
        chk("dis_valid", rx_valid, 1'b0);
        chk("dis_pulses", {rx_frame_err, rx_overrun}, 2'b00);
        chk("dis_state", dut.state, uart_pkg::IDLE);
        chk("dis_comp_c", dut.comp_c, 16'd0);
        uart_rx = 1'b1;
        tick(20);
        rec_en = 1'b1;
        tick(3);
        send_frame(8'h81, 1'b1, 1, -1, t0);
        chk("reen_data", rx_data, 8'h81);
        chk("reen_valid", rx_valid, 1'b1);

        uart_rx = 1'b0;
        tick(60);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_data", rx_data, 8'h00);
        chk("arst_valid", rx_valid, 1'b0);
        chk("arst_state", dut.state, uart_pkg::IDLE);
        tick();
        uart_rx = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b1, 1, -1, t0);
        chk("arst_next_data", rx_data, 8'h5A);
        chk("arst_next_valid", rx_valid, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver; the downstream peer of the team's UART transmitter, consuming its `uart_tx` line (directly in loopback, or via pin). It uses the same `comp` bit-period convention, so one `comp` value configures both ends. It detects the start bit, samples 8 data bits LSB-first at mid-bit, checks the first stop bit, and presents each byte on a valid/ack handshake with frame-error and overrun pulses.

## Interface
Parameters:
- none; the data width is fixed at 8 bits and `comp` is 16 bits, matching the transmitter.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `comp` in 16: bit period minus one, in clocks (bit = `comp`+1 cycles); latched at start detect.
- `rec_en` in 1: receiver enable; low = synchronous clear.
- `uart_rx` in 1: serial line, asynchronous, idle high.
- `rx_ack` in 1: consumer acknowledges the held byte.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unacknowledged byte.
- `rx_frame_err` out 1: 1-cycle pulse, stop bit sampled 0.
- `rx_overrun` out 1: 1-cycle pulse, byte dropped because `rx_valid` was still set.

## Operation
- `uart_rx` passes through a 2-flop synchronizer (both flops reset to 1) giving `rx_s`; a third flop `rx_p` holds the previous `rx_s`. The synchronizer runs regardless of `rec_en`.
- `half` = `comp_int >> 1`; counters: `comp_c` 16 bits, `bit_c` 4 bits, shift register 8 bits.
- States:
  - IDLE → START when `rx_p`=1 and `rx_s`=0 (falling edge only; a line stuck low never restarts reception). Latch `comp_int`←`comp`, `comp_c`←0.
  - START: `comp_c`++ each cycle. When `comp_c`==`half`, sample `rx_s`. If 1 (glitch) → IDLE. If 0 → RECEIVE, `comp_c`←0, `bit_c`←0.
  - RECEIVE: `comp_c`++. When `comp_c`>=`comp_int`: shift `rx_s` into the MSB (LSB-first line order), `comp_c`←0, `bit_c`++. On the 8th sample → STOP.
  - STOP: `comp_c`++. When `comp_c`>=`comp_int`, sample `rx_s` and go to IDLE. If the sample is 0: pulse `rx_frame_err`; data is not delivered. If 1: deliver.
- Deliver:
  - If `rx_valid`=0, or `rx_ack`=1 in the same cycle: `rx_data`←shift register, `rx_valid`←1.
  - Otherwise: `rx_data` is unchanged and `rx_overrun` pulses.
- Handshake: `rx_valid`=1 and `rx_ack`=1 with no simultaneous deliver clears `rx_valid` next cycle. `rx_ack` while `rx_valid`=0 is ignored.
- Additional stop bits (`stop_sel`>0 at the transmitter) are not checked. They appear as idle high, so the next falling edge starts a new frame.
- `rec_en`=0: next edge forces state IDLE and clears all counters, registers and outputs to their reset values.

## Timing
- Reset values:
  - `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_overrun`=0.
  - State IDLE, counters 0, synchronizer flops 1.
- Detection lags the pin edge by 2 cycles (synchronizer).
- Let D be the IDLE cycle that detects the edge. The START sample falls at D+1+`half`. Data bit k is sampled at D+1+(`half`+1)+(k+1)(`comp`+1)−1.
- `rx_valid` / `rx_frame_err` / `rx_overrun` become visible at cycle D+`half`+2+9(`comp`+1).
- The first cycle after STOP is IDLE, so back-to-back frames are accepted with zero idle time.
- Supported `comp` ≥ 3; smaller values give undefined sampling margin.
- `comp_c` never wraps: comparisons use `>=`, and the counter is cleared on every sample.
- Asynchronous reset mid-frame aborts immediately; the partial byte is discarded.

## Structure
- Shared package `uart_pkg`: state encodings (IDLE, START, RECEIVE, STOP), data-width constant 8, comp width 16. The transmitter adopts the same package.
- One sub-module, `sync_2ff` (reset value 1), for the `uart_rx` synchronizer. It is reusable for any asynchronous input.

## Test plan
- `comp`=15, line drives 0xA5 with 1 stop bit → `rx_valid`=1 at D+153, `rx_data`=0xA5; `rx_ack` the next cycle → `rx_valid`=0 one cycle later.
- Loopback from the transmitter with `comp`=15, `stop_sel`=1, `tx_data`=0x3C, then 0xFF back-to-back → two deliveries, 0x3C and 0xFF, no error pulses.
- 4-cycle low glitch on `uart_rx` with `comp`=15 → returns to IDLE at the START sample; no output pulses.
- Frame 0x55 with stop bit forced 0 → `rx_frame_err` high for exactly 1 cycle; `rx_valid` stays 0; the next clean frame 0x12 is received.
- Two frames 0x11 and 0x22 without `rx_ack` → `rx_data`=0x11 held, `rx_overrun` pulses once. Repeat with `rx_ack`=1 on the deliver cycle → `rx_data`=0x22, no overrun.
- `rec_en` dropped mid-RECEIVE → next cycle all outputs are at reset values. Re-enable and send 0x81 → 0x81 received correctly.
